d_cache_wb: RTL and testbench
=============================

# d_cache_wb

Parametrised two-way set-associative, write-back, write-allocate data cache with multi-word lines and AXI INCR burst refill and writeback. It is the next generation of the single-word D-cache and sits between the MEM stage of the pipelined MIPS core and the AXI arbiter. Hits return data and complete writes in the request cycle. Misses stall the core while an optional dirty-victim writeback and a line refill run on AXI.

## Interface
- INDEX_WIDTH, 7: set index bits; SETS = 2^INDEX_WIDTH.
- OFFSET_WIDTH, 4: byte-offset bits within a line, minimum 2, maximum 10. LINE_WORDS = 2^(OFFSET_WIDTH-2). TAG_WIDTH = 32-INDEX_WIDTH-OFFSET_WIDTH.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_en  in  1  request valid; held stable with addr/wen/wdata while stall=1.
- data_addr  in  32  byte address; word-aligned.
- data_wen  in  4  byte write enables; 0 means read.
- data_wdata  in  32  store data.
- data_rdata  out  32  load data; valid when data_en & read & ~stall.
- stall  out  1  request not complete this cycle.
- hit  out  1  lookup hit in IDLE.
- araddr  out  32  {tag,index,0}, line-aligned.
- arlen  out  8  LINE_WORDS-1.
- arvalid  out  1
- arready  in  1
- rdata  in  32
- rlast  in  1
- rvalid  in  1
- rready  out  1
- awaddr  out  32  {victim tag,index,0}.
- awlen  out  8  LINE_WORDS-1.
- awsize  out  3  constant 3'b010.
- awvalid  out  1
- awready  in  1
- wdata  out  32  victim word selected by the beat counter.
- wstrb  out  4  constant 4'b1111.
- wlast  out  1  asserted on beat LINE_WORDS-1.
- wvalid  out  1
- wready  in  1
- bvalid  in  1
- bready  out  1

## Operation
- Storage is register arrays per way: valid[SETS], dirty[SETS], tag[SETS], and data[SETS][LINE_WORDS]. One LRU bit per set names the next victim. Only data is not reset.
- Lookup in IDLE is combinational: hit = valid & tag match in either way. Both ways matching cannot occur.
- Read hit: data_rdata is the matched word; stall=0.
- Write hit: byte-merge data_wen into the matched word at the clock edge; set dirty for that way/set.
- Any hit: the LRU bit for the set is set to the way that did not hit.
- Victim selection: way0 if invalid, else way1 if invalid, else the way given by LRU.
- FSM states: IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R.
- IDLE, miss: go to WB_AW if the victim is valid and dirty, else to RD_AR. Victim way, tag and index are latched at this transition.
- WB_AW: awvalid=1; on awready go to WB_W.
- WB_W: wvalid=1, beat counter 0..LINE_WORDS-1; counter advances on wready; on the wlast handshake go to WB_B.
- WB_B: bready=1; on bvalid go to RD_AR. bresp is ignored.
- RD_AR: arvalid=1; on arready go to RD_R.
- RD_R: rready=1; each rvalid beat writes rdata into the victim line at the counter position. On the rlast beat, set valid=1, tag=request tag, dirty=0, LRU=other way, then go to IDLE. rresp is ignored.
- Back in IDLE the held request re-looks-up and hits. A write merges and sets dirty in that cycle.
- stall = (state!=IDLE) | (data_en & ~hit).
- Request with data_en=0: no state change and no LRU update.

## Timing
- Reset (rst=0) asynchronously forces the following:
  - state=IDLE, counters=0, valid/dirty/LRU all 0.
  - arvalid, awvalid, wvalid, rready, bready = 0.
  - stall = data_en (all lines invalid); hit=0.
- Reset mid-burst abandons the AXI transaction; the interconnect is reset in the same domain.
- Hit latency is 0: the result is in the request cycle.
- Clean-miss latency with an ideal slave (ready always high, data back-to-back): AR in cycle 1, R beats in cycles 2..LINE_WORDS+1, hit in cycle LINE_WORDS+2.
- Dirty miss adds AW (1 cycle) + LINE_WORDS W beats + B (≥1 cycle) before AR.
- Valid signals rise the cycle after entering a state. They stay high and their payload stays constant until the handshake completes; they never depend combinationally on ready.
- rvalid outside RD_R and bvalid outside WB_B are ignored.

## Test plan
- Cold read of 0x0000_1004 (defaults) → stall high, arvalid with araddr=0x0000_1000 and arlen=3; slave returns words A0..A3 → the next IDLE cycle has stall=0 and data_rdata=A1.
- Read 0x1008 after that fill → hit=1, stall=0, data_rdata=A2, no AXI activity.
- sb via wen=4'b0010 with wdata=0x0000_AB00 to 0x1000 (A0=0x11223344) → no stall, then a read returns 0x1122AB44; dirty set.
- Fill way1 with 0x0000_9000, read 0x1000 (LRU→way1), then read 0x0001_1000 → way1 victim, clean, so no AW; LRU unchanged for way0 data.
- Dirty eviction: dirty 0x1000 in both ways, then miss on 0x0002_1000 → awaddr=victim line, four W beats with wlast on beat 3, B, then AR for 0x0002_1000.
- Assert rst low during beat 2 of RD_R → all AXI valid/ready outputs 0 immediately; a re-read of the same address misses again.

Source files
------------

// File: rtl/d_cache_wb.sv
// Two-way set-associative write-back/write-allocate data cache with LRU replacement.
// Hits finish in the request cycle; misses evict a dirty victim and refill over AXI INCR bursts.
module d_cache_wb #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        stall,
  output logic        hit,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << (OFFSET_WIDTH - 2);
  localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int CNT_W      = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;

  typedef enum logic [2:0] {IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   victimWay_q, victimWay_d;
  logic [TAG_WIDTH-1:0]   victimTag_q, victimTag_d;
  logic [TAG_WIDTH-1:0]   missTag_q, missTag_d;
  logic [INDEX_WIDTH-1:0] lineIdx_q, lineIdx_d;

  logic [SETS-1:0]        valid_q [2];
  logic [SETS-1:0]        dirty_q [2];
  logic [SETS-1:0]        lru_q;
  logic [TAG_WIDTH-1:0]   tag_q   [2][SETS];
  logic [31:0]            data_q  [2][SETS][LINE_WORDS];

  logic [TAG_WIDTH-1:0]   reqTag;
  logic [INDEX_WIDTH-1:0] reqIdx;
  logic [CNT_W-1:0]       wordSel;
  logic                   hit0, hit1, hitAny, hitWay, victimSel, lastBeat;
  logic                   lookupHit, writeHit, refillBeat, refillDone;
  logic                   unusedAddrBits;

  assign reqTag = data_addr[31 -: TAG_WIDTH];
  assign reqIdx = data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unusedAddrBits = ^data_addr[1:0];

  if (OFFSET_WIDTH > 2) begin : gWordSel
    assign wordSel = data_addr[2 +: CNT_W];
  end else begin : gSingleWord
    assign wordSel = '0;
  end

  assign hit0      = valid_q[0][reqIdx] && (tag_q[0][reqIdx] == reqTag);
  assign hit1      = valid_q[1][reqIdx] && (tag_q[1][reqIdx] == reqTag);
  assign hitAny    = hit0 | hit1;
  assign hitWay    = hit1;
  assign victimSel = !valid_q[0][reqIdx] ? 1'b0 :
                     !valid_q[1][reqIdx] ? 1'b1 : lru_q[reqIdx];
  assign lastBeat  = (cnt_q == CNT_W'(LINE_WORDS - 1));

  assign lookupHit  = (state_q == IDLE) && data_en && hitAny;
  assign writeHit   = lookupHit && (|data_wen);
  assign refillBeat = (state_q == RD_R) && rvalid;
  assign refillDone = refillBeat && rlast;

  assign hit        = (state_q == IDLE) && hitAny;
  assign stall      = (state_q != IDLE) || (data_en && !hitAny);
  assign data_rdata = data_q[hitWay][reqIdx][wordSel];

  assign araddr  = {missTag_q, lineIdx_q, {OFFSET_WIDTH{1'b0}}};
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arvalid = (state_q == RD_AR);
  assign rready  = (state_q == RD_R);
  assign awaddr  = {victimTag_q, lineIdx_q, {OFFSET_WIDTH{1'b0}}};
  assign awlen   = 8'(LINE_WORDS - 1);
  assign awsize  = 3'b010;
  assign awvalid = (state_q == WB_AW);
  assign wdata   = data_q[victimWay_q][lineIdx_q][cnt_q];
  assign wstrb   = 4'b1111;
  assign wvalid  = (state_q == WB_W);
  assign wlast   = (state_q == WB_W) && lastBeat;
  assign bready  = (state_q == WB_B);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      victimWay_q <= 1'b0;
      victimTag_q <= '0;
      missTag_q   <= '0;
      lineIdx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      victimWay_q <= victimWay_d;
      victimTag_q <= victimTag_d;
      missTag_q   <= missTag_d;
      lineIdx_q   <= lineIdx_d;
    end
  end

  // The victim is chosen and frozen on the miss so the burst addresses stay put.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    victimWay_d = victimWay_q;
    victimTag_d = victimTag_q;
    missTag_d   = missTag_q;
    lineIdx_d   = lineIdx_q;
    case (state_q)
      IDLE: begin
        if (data_en && !hitAny) begin
          victimWay_d = victimSel;
          victimTag_d = tag_q[victimSel][reqIdx];
          missTag_d   = reqTag;
          lineIdx_d   = reqIdx;
          cnt_d       = '0;
          state_d     = (valid_q[victimSel][reqIdx] && dirty_q[victimSel][reqIdx]) ? WB_AW : RD_AR;
        end
      end
      WB_AW: if (awready) state_d = WB_W;
      WB_W: begin
        if (wready) begin
          if (lastBeat) begin
            cnt_d   = '0;
            state_d = WB_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WB_B:  if (bvalid) state_d = RD_AR;
      RD_AR: if (arready) state_d = RD_R;
      RD_R: begin
        if (rvalid) begin
          if (rlast) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // LRU holds the way to evict next, so a hit points it at the other way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      tag_q[0]   <= '{default: '0};
      tag_q[1]   <= '{default: '0};
    end else begin
      if (lookupHit) begin
        lru_q[reqIdx] <= hit0;
        if (|data_wen) dirty_q[hitWay][reqIdx] <= 1'b1;
      end
      if (refillDone) begin
        valid_q[victimWay_q][lineIdx_q] <= 1'b1;
        dirty_q[victimWay_q][lineIdx_q] <= 1'b0;
        tag_q[victimWay_q][lineIdx_q]   <= missTag_q;
        lru_q[lineIdx_q]                <= ~victimWay_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (writeHit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wen[b]) data_q[hitWay][reqIdx][wordSel][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
    if (refillBeat) data_q[victimWay_q][lineIdx_q][cnt_q] <= rdata;
  end

endmodule

// File: tb/tb_d_cache_wb.sv
// Directed bench for d_cache_wb: fills, hits, byte stores, LRU victims, dirty eviction, reset mid-burst.
// A scripted AXI slave answers bursts from expected line contents held in the bench.
module tb_d_cache_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_en;
  logic [31:0] data_addr;
  logic [3:0]  data_wen;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stall, hit;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  awsize;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] lineWords [4];
  logic [31:0] wbWords [4];
  logic        sawAw;
  int          arWait;

  always #5 clk = ~clk;

  d_cache_wb dut (
    .clk(clk), .rst(rst),
    .data_en(data_en), .data_addr(data_addr), .data_wen(data_wen), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .stall(stall), .hit(hit),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  // Waits for AR, then streams lineWords back; an optional empty cycle precedes beat gapBeat.
  task automatic serve_read(input logic [31:0] expAddr, input int gapBeat, input string name);
    arWait = 0;
    sawAw  = 1'b0;
    arready = 1'b1;
    while (!arvalid && arWait < 40) begin
      sawAw |= awvalid;
      @(negedge clk); #1;
      arWait++;
    end
    sawAw |= awvalid;
    testsRun++;
    if (arvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s arvalid: got %b required 1 (timeout)", name, arvalid); end
    testsRun++;
    if (araddr !== expAddr) begin testsFailed++; $display("[TB] FAIL %s araddr: got %h required %h", name, araddr, expAddr); end
    testsRun++;
    if (arlen !== 8'd3) begin testsFailed++; $display("[TB] FAIL %s arlen: got %0d required 3", name, arlen); end
    @(negedge clk);
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == gapBeat) begin
        rvalid = 1'b0;
        @(negedge clk);
      end
      rvalid = 1'b1;
      rdata  = lineWords[i];
      rlast  = (i == 3);
      #1;
      testsRun++;
      if (rready !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s rready beat %0d: got %b required 1", name, i, rready); end
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    #1;
  endtask

  // Accepts AW, checks the four victim words (with one wait state on beat 1), then answers B late.
  task automatic serve_write(input logic [31:0] expAddr, input string name);
    int waitCycles = 0;
    while (!awvalid && waitCycles < 40) begin
      @(negedge clk); #1;
      waitCycles++;
    end
    testsRun++;
    if (awvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s awvalid: got %b required 1 (timeout)", name, awvalid); end
    testsRun++;
    if (awaddr !== expAddr) begin testsFailed++; $display("[TB] FAIL %s awaddr: got %h required %h", name, awaddr, expAddr); end
    testsRun++;
    if ({awlen, awsize} !== {8'd3, 3'b010}) begin testsFailed++; $display("[TB] FAIL %s awlen/awsize: got %0d/%b required 3/010", name, awlen, awsize); end
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if ({wvalid, wlast, wstrb} !== {1'b1, (i == 3), 4'hF}) begin
        testsFailed++; $display("[TB] FAIL %s wvalid/wlast/wstrb beat %0d: got %b/%b/%h required 1/%b/f", name, i, wvalid, wlast, wstrb, (i == 3));
      end
      testsRun++;
      if (wdata !== wbWords[i]) begin testsFailed++; $display("[TB] FAIL %s wdata beat %0d: got %h required %h", name, i, wdata, wbWords[i]); end
      if (i == 1) begin
        @(negedge clk); #1;
        testsRun++;
        if ({wvalid, wdata} !== {1'b1, wbWords[1]}) begin testsFailed++; $display("[TB] FAIL %s wdata held: got %b/%h required 1/%h", name, wvalid, wdata, wbWords[1]); end
      end
      wready = 1'b1;
      @(negedge clk);
      wready = 1'b0;
      #1;
    end
    testsRun++;
    if ({bready, arvalid, wvalid} !== 3'b100) begin testsFailed++; $display("[TB] FAIL %s B wait: got bready/arvalid/wvalid %b required 100", name, {bready, arvalid, wvalid}); end
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    rlast  = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    rlast  = 1'b0;
    bvalid = 1'b1;
    #1;
    testsRun++;
    if (bready !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s bready: got %b required 1", name, bready); end
    @(negedge clk);
    bvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    data_en = 1'b1; data_addr = 32'h0000_1004; data_wen = 4'h0; data_wdata = '0;
    arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    #2;
    testsRun++;
    if ({stall, hit} !== 2'b10) begin testsFailed++; $display("[TB] FAIL reset stall/hit: got %b required 10", {stall, hit}); end
    testsRun++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      testsFailed++; $display("[TB] FAIL reset axi valids: got %b required 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    data_en = 1'b0;
    #1;
    testsRun++;
    if (stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset stall idle: got %b required 0", stall); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cold_read;
    lineWords = '{32'h1122_3344, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'hA3A3_A3A3};
    @(negedge clk);
    data_en = 1'b1; data_addr = 32'h0000_1004; data_wen = 4'h0;
    #1;
    testsRun++;
    if ({stall, hit} !== 2'b10) begin testsFailed++; $display("[TB] FAIL cold stall/hit: got %b required 10", {stall, hit}); end
    serve_read(32'h0000_1000, -1, "cold");
    testsRun++;
    if (arWait !== 1) begin testsFailed++; $display("[TB] FAIL cold ar latency: got %0d required 1", arWait); end
    testsRun++;
    if (sawAw !== 1'b0) begin testsFailed++; $display("[TB] FAIL cold no aw: got %b required 0", sawAw); end
    testsRun++;
    if ({stall, hit} !== 2'b01) begin testsFailed++; $display("[TB] FAIL cold refill done stall/hit: got %b required 01", {stall, hit}); end
    testsRun++;
    if (data_rdata !== 32'hA1A1_A1A1) begin testsFailed++; $display("[TB] FAIL cold rdata: got %h required a1a1a1a1", data_rdata); end
  endtask

  task automatic test_read_hit;
    @(negedge clk);
    data_addr = 32'h0000_1008;
    #1;
    testsRun++;
    if ({stall, hit, data_rdata} !== {2'b01, 32'hA2A2_A2A2}) begin
      testsFailed++; $display("[TB] FAIL read hit: got stall/hit %b rdata %h required 01 a2a2a2a2", {stall, hit}, data_rdata);
    end
    @(negedge clk);
    data_en = 1'b0; data_addr = 32'h0000_5000;
    #1;
    testsRun++;
    if ({arvalid, awvalid, stall, hit} !== 4'b0) begin testsFailed++; $display("[TB] FAIL idle request: got %b required 0000", {arvalid, awvalid, stall, hit}); end
    @(negedge clk); #1;
    testsRun++;
    if ({arvalid, awvalid, stall} !== 3'b0) begin testsFailed++; $display("[TB] FAIL no request no fsm: got %b required 000", {arvalid, awvalid, stall}); end
  endtask

  task automatic test_write_hit;
    @(negedge clk);
    data_en = 1'b1; data_addr = 32'h0000_1000; data_wen = 4'b0010; data_wdata = 32'h0000_AB00;
    #1;
    testsRun++;
    if ({stall, hit} !== 2'b01) begin testsFailed++; $display("[TB] FAIL store hit stall/hit: got %b required 01", {stall, hit}); end
    @(negedge clk);
    data_wen = 4'h0; data_wdata = '0;
    #1;
    testsRun++;
    if (data_rdata !== 32'h1122_AB44) begin testsFailed++; $display("[TB] FAIL store merge: got %h required 1122ab44", data_rdata); end
  endtask

  task automatic test_lru_victim;
    lineWords = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    @(negedge clk);
    data_addr = 32'h0000_9000;
    #1;
    testsRun++;
    if (stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL way1 fill stall: got %b required 1", stall); end
    serve_read(32'h0000_9000, 2, "fill 9000");
    testsRun++;
    if ({sawAw, stall, data_rdata} !== {2'b00, 32'hB000_0000}) begin
      testsFailed++; $display("[TB] FAIL fill 9000 result: got aw/stall %b rdata %h required 00 b0000000", {sawAw, stall}, data_rdata);
    end
    @(negedge clk);
    data_addr = 32'h0000_1000;
    #1;
    testsRun++;
    if ({hit, data_rdata} !== {1'b1, 32'h1122_AB44}) begin testsFailed++; $display("[TB] FAIL way0 kept: got hit %b rdata %h required 1 1122ab44", hit, data_rdata); end
    lineWords = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
    @(negedge clk);
    data_addr = 32'h0001_1008;
    #1;
    serve_read(32'h0001_1000, -1, "lru 11000");
    testsRun++;
    if ({sawAw, stall, data_rdata} !== {2'b00, 32'hC000_0002}) begin
      testsFailed++; $display("[TB] FAIL lru 11000 result: got aw/stall %b rdata %h required 00 c0000002", {sawAw, stall}, data_rdata);
    end
    @(negedge clk);
    data_addr = 32'h0000_1000;
    #1;
    testsRun++;
    if ({hit, data_rdata} !== {1'b1, 32'h1122_AB44}) begin testsFailed++; $display("[TB] FAIL lru kept way0: got hit %b rdata %h required 1 1122ab44", hit, data_rdata); end
  endtask

  task automatic test_dirty_evict;
    @(negedge clk);
    data_addr = 32'h0001_1004; data_wen = 4'hF; data_wdata = 32'hCAFE_F00D;
    #1;
    testsRun++;
    if ({stall, hit} !== 2'b01) begin testsFailed++; $display("[TB] FAIL way1 store: got stall/hit %b required 01", {stall, hit}); end
    wbWords   = '{32'h1122_AB44, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'hA3A3_A3A3};
    lineWords = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
    @(negedge clk);
    data_addr = 32'h0002_1000; data_wen = 4'h0; data_wdata = '0;
    #1;
    testsRun++;
    if ({stall, arvalid} !== 2'b10) begin testsFailed++; $display("[TB] FAIL evict start: got stall/arvalid %b required 10", {stall, arvalid}); end
    serve_write(32'h0000_1000, "evict");
    serve_read(32'h0002_1000, -1, "evict refill");
    testsRun++;
    if ({stall, data_rdata} !== {1'b0, 32'hD000_0000}) begin testsFailed++; $display("[TB] FAIL evict refill data: got stall %b rdata %h required 0 d0000000", stall, data_rdata); end
    @(negedge clk);
    data_addr = 32'h0001_1004;
    #1;
    testsRun++;
    if ({hit, data_rdata} !== {1'b1, 32'hCAFE_F00D}) begin testsFailed++; $display("[TB] FAIL way1 store kept: got hit %b rdata %h required 1 cafef00d", hit, data_rdata); end
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk);
    data_addr = 32'h0000_2014;
    #1;
    @(negedge clk); #1;
    testsRun++;
    if ({arvalid, araddr} !== {1'b1, 32'h0000_2010}) begin testsFailed++; $display("[TB] FAIL burst ar: got %b %h required 1 00002010", arvalid, araddr); end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata = 32'hE000_0000 + i; rlast = 1'b0;
      if (i < 2) @(negedge clk);
    end
    #1;
    testsRun++;
    if (rready !== 1'b1) begin testsFailed++; $display("[TB] FAIL burst beat2 rready: got %b required 1", rready); end
    rst = 1'b0;
    #1;
    testsRun++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      testsFailed++; $display("[TB] FAIL async reset axi: got %b required 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    @(negedge clk);
    rvalid = 1'b0;
    rst = 1'b1;
    #1;
    testsRun++;
    if ({stall, hit} !== 2'b10) begin testsFailed++; $display("[TB] FAIL reread misses: got stall/hit %b required 10", {stall, hit}); end
    @(negedge clk); #1;
    testsRun++;
    if ({arvalid, araddr} !== {1'b1, 32'h0000_2010}) begin testsFailed++; $display("[TB] FAIL reread ar: got %b %h required 1 00002010", arvalid, araddr); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    data_addr = 32'h0000_1000;
    #1;
    testsRun++;
    if ({stall, hit} !== 2'b10) begin testsFailed++; $display("[TB] FAIL old line dropped: got stall/hit %b required 10", {stall, hit}); end
    data_en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_cold_read;
    test_read_hit;
    test_write_hit;
    test_lru_victim;
    test_dirty_evict;
    test_reset_mid_burst;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
